snes_pad_reader: RTL
====================

SNES_PAD_READER -- requirements
Module: snes_pad_reader

Interface
REQ-001 SHALL have parameter DIV, default 300, meaning clk cycles per pad_clk half-period and per latch half-width; legal range DIV >= 4.
REQ-002 SHALL have parameter POLL, default 833333, meaning clk cycles between consecutive frame starts; legal range POLL > 36*DIV.
REQ-003 SHALL have port clk, input, 1 bit, the single system clock.
REQ-004 SHALL have port rst, input, 1 bit, reset: asynchronous, active-low.
REQ-005 SHALL have port pad_data, input, 1 bit, serial data from the controller, asynchronous to clk, active-low (0 = pressed).
REQ-006 SHALL have port pad_latch, output, 1 bit, the controller latch strobe.
REQ-007 SHALL have port pad_clk, output, 1 bit, the controller shift clock, idle high.
REQ-008 SHALL have port buttons, output, 12 bits, active-high pressed flags, bit map: 0 B, 1 Y, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right, 8 A, 9 X, 10 L, 11 R.
REQ-009 SHALL have port pad_present, output, 1 bit, high when the last frame read raw bits 12..15 all equal to 1.
REQ-010 SHALL have port frame_valid, output, 1 bit, a one-cycle pulse on each frame completion.
REQ-011 SHALL have port state, output, 2 bits, the controller_state code for the game FSM.
REQ-012 SHALL have ports left_p, right_p and center_p, each output, 1 bit, one-cycle press pulses.

Function
REQ-013 SHALL pass pad_data through a 2-flop synchronizer; all sampling SHALL use the synchronized value.
REQ-014 SHALL implement the FSM with these states and transitions:
- IDLE -> LATCH on a poll tick.
- LATCH -> CLK_LO.
- CLK_LO -> CLK_HI.
- CLK_HI -> CLK_LO while pulses < 16, else CLK_HI -> DONE.
- DONE -> IDLE.
REQ-015 SHALL raise a poll tick on the first cycle after reset release, then every POLL cycles, counted start-to-start.
REQ-016 In LATCH, SHALL drive pad_latch = 1 for exactly 2*DIV cycles, with pad_clk = 1.
REQ-017 In CLK_LO, SHALL drive pad_clk = 0 for DIV cycles; in CLK_HI, SHALL drive pad_clk = 1 for DIV cycles; a frame SHALL contain exactly 16 low pulses.
REQ-018 SHALL sample raw bit 0 in the last LATCH cycle, and raw bit k (k = 1..15) in the last CLK_HI cycle of pulse k; the pulse-16 sample SHALL be discarded.
REQ-019 In DONE, for one cycle, SHALL:
- set pad_present = AND(raw[15:12]);
- set buttons = pad_present ? ~raw[11:0] : 0;
- assert frame_valid.
REQ-020 SHALL hold buttons and pad_present constant between DONE cycles.
REQ-021 SHALL derive state combinationally from registered buttons, with priority Left > Right > A:
- Left (bit 6) -> 2'b10.
- Right (bit 7) -> 2'b01.
- A (bit 8) -> 2'b11.
- none -> 2'b00.
REQ-022 SHALL assert left_p / right_p / center_p in the frame_valid cycle when bit 6 / 7 / 8 was 0 in the previous frame and is 1 in the new frame; other cycles SHALL be 0.
REQ-023 SHALL allow multiple simultaneous press pulses; state priority SHALL NOT mask them.
REQ-024 SHALL allow any latency from pad_data to buttons up to one POLL period plus one frame; no input back-pressure exists.
REQ-025 A poll tick arriving while not in IDLE (illegal POLL) SHALL be ignored, with no frame overlap.
REQ-026 On a frame with pad_present = 0, SHALL report no press pulses, and the next present frame SHALL compare against all-zero.

Reset
REQ-027 rst low SHALL immediately force the FSM to IDLE and set these values:
- pad_latch = 0, pad_clk = 1.
- buttons = 0, pad_present = 0.
- frame_valid = 0, state = 00.
- all press pulses = 0.
- all counters and synchronizer flops = 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no partial update; after release, a fresh frame SHALL start on the first clk cycle.

Verification
REQ-029 Use DIV=4, POLL=200, pad model returning Left pressed -> first frame: pad_latch high for 8 cycles, 16 pad_clk low pulses of 4 cycles, buttons=12'h040, state=10, left_p pulse in the frame_valid cycle.
REQ-030 Hold Left for two frames -> second frame: buttons=12'h040, left_p stays 0.
REQ-031 Press Left+Right+A -> state=10, with left_p, right_p and center_p all pulsing together.
REQ-032 Drive pad_data constant 0 (no pad) -> pad_present=0, buttons=0, state=00, no pulses.
REQ-033 Assert rst during pulse 7 -> pad_clk=1, pad_latch=0 and all outputs 0 asynchronously; after release, a new LATCH starts next cycle.
REQ-034 Measure frame start spacing -> frame starts exactly 200 cycles apart, frame_valid exactly once per frame.

Source files
------------

// File: rtl/snes_pad_reader.sv
// SNES controller reader: drives the latch/shift-clock strobes, samples the 16-bit serial frame,
// and publishes decoded buttons, pad presence, a steering state code and one-cycle press pulses.
module snes_pad_reader #(
    parameter int DIV  = 300,
    parameter int POLL = 833333
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pad_data,
    output logic        pad_latch,
    output logic        pad_clk,
    output logic [11:0] buttons,
    output logic        pad_present,
    output logic        frame_valid,
    output logic [1:0]  state,
    output logic        left_p,
    output logic        right_p,
    output logic        center_p
);
    localparam int DW = $clog2(2 * DIV);
    localparam int PW = $clog2(POLL);
    localparam logic [DW-1:0] LAT_END  = DW'(2 * DIV - 1);
    localparam logic [DW-1:0] HALF_END = DW'(DIV - 1);
    localparam logic [DW-1:0] CNT_ONE  = DW'(1);
    localparam logic [PW-1:0] POLL_END = PW'(POLL - 1);
    localparam logic [PW-1:0] POLL_ONE = PW'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_CLK_LO = 3'd2,
        ST_CLK_HI = 3'd3,
        ST_DONE   = 3'd4
    } fsm_t;

    // Raw frame bits are active-low; an absent pad (upper nibble not all ones) reports nothing.
    function automatic logic [11:0] decode_buttons(input logic [15:0] raw);
        decode_buttons = (&raw[15:12]) ? ~raw[11:0] : 12'h000;
    endfunction

    logic          sync1_r;
    logic          sync2_r;
    logic [PW-1:0] poll_cnt_r;
    logic          poll_tick_s;
    fsm_t          fsm_r;
    logic [DW-1:0] div_cnt_r;
    logic [4:0]    pulse_cnt_r;
    logic [15:0]   raw_r;
    logic          pad_latch_r;
    logic          pad_clk_r;
    logic [11:0]   buttons_r;
    logic          present_r;
    logic          frame_valid_r;
    logic          left_p_r;
    logic          right_p_r;
    logic          center_p_r;
    logic [11:0]   new_buttons_s;
    logic [1:0]    state_s;

    // Two-flop synchronizer for the asynchronous pad data line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= pad_data;
            sync2_r <= sync1_r;
        end
    end

    // Free-running poll counter; the tick fires whenever it sits at zero, so right after reset too.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            poll_cnt_r <= {PW{1'b0}};
        end else if (poll_cnt_r == POLL_END) begin
            poll_cnt_r <= {PW{1'b0}};
        end else begin
            poll_cnt_r <= poll_cnt_r + POLL_ONE;
        end
    end

    assign poll_tick_s   = (poll_cnt_r == {PW{1'b0}});
    assign new_buttons_s = decode_buttons(raw_r);

    // Frame sequencer: strobe generation, bit sampling and the end-of-frame publish.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_r         <= ST_IDLE;
            div_cnt_r     <= {DW{1'b0}};
            pulse_cnt_r   <= 5'd0;
            raw_r         <= 16'h0000;
            pad_latch_r   <= 1'b0;
            pad_clk_r     <= 1'b1;
            buttons_r     <= 12'h000;
            present_r     <= 1'b0;
            frame_valid_r <= 1'b0;
            left_p_r      <= 1'b0;
            right_p_r     <= 1'b0;
            center_p_r    <= 1'b0;
        end else begin
            frame_valid_r <= 1'b0;
            left_p_r      <= 1'b0;
            right_p_r     <= 1'b0;
            center_p_r    <= 1'b0;
            case (fsm_r)
                ST_IDLE: begin
                    pad_clk_r <= 1'b1;
                    if (poll_tick_s) begin
                        fsm_r       <= ST_LATCH;
                        pad_latch_r <= 1'b1;
                        div_cnt_r   <= {DW{1'b0}};
                        pulse_cnt_r <= 5'd0;
                    end else begin
                        pad_latch_r <= 1'b0;
                    end
                end
                ST_LATCH: begin
                    if (div_cnt_r == LAT_END) begin
                        raw_r[0]    <= sync2_r;
                        fsm_r       <= ST_CLK_LO;
                        pad_latch_r <= 1'b0;
                        pad_clk_r   <= 1'b0;
                        div_cnt_r   <= {DW{1'b0}};
                    end else begin
                        div_cnt_r <= div_cnt_r + CNT_ONE;
                    end
                end
                ST_CLK_LO: begin
                    if (div_cnt_r == HALF_END) begin
                        fsm_r       <= ST_CLK_HI;
                        pad_clk_r   <= 1'b1;
                        div_cnt_r   <= {DW{1'b0}};
                        pulse_cnt_r <= pulse_cnt_r + 5'd1;
                    end else begin
                        div_cnt_r <= div_cnt_r + CNT_ONE;
                    end
                end
                ST_CLK_HI: begin
                    if (div_cnt_r == HALF_END) begin
                        div_cnt_r <= {DW{1'b0}};
                        // pulse_cnt_r already names the pulse just completed; pulse 16 is not stored.
                        if (pulse_cnt_r < 5'd16) begin
                            raw_r[pulse_cnt_r[3:0]] <= sync2_r;
                            fsm_r     <= ST_CLK_LO;
                            pad_clk_r <= 1'b0;
                        end else begin
                            fsm_r         <= ST_DONE;
                            frame_valid_r <= 1'b1;
                            present_r     <= &raw_r[15:12];
                            buttons_r     <= new_buttons_s;
                            left_p_r      <= new_buttons_s[6] & ~buttons_r[6];
                            right_p_r     <= new_buttons_s[7] & ~buttons_r[7];
                            center_p_r    <= new_buttons_s[8] & ~buttons_r[8];
                        end
                    end else begin
                        div_cnt_r <= div_cnt_r + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    fsm_r <= ST_IDLE;
                end
                default: begin
                    fsm_r       <= ST_IDLE;
                    pad_latch_r <= 1'b0;
                    pad_clk_r   <= 1'b1;
                end
            endcase
        end
    end

    // Steering code with Left > Right > A priority.
    always_comb begin
        state_s = 2'b00;
        if (buttons_r[6]) begin
            state_s = 2'b10;
        end else if (buttons_r[7]) begin
            state_s = 2'b01;
        end else if (buttons_r[8]) begin
            state_s = 2'b11;
        end else begin
            state_s = 2'b00;
        end
    end

    assign pad_latch   = pad_latch_r;
    assign pad_clk     = pad_clk_r;
    assign buttons     = buttons_r;
    assign pad_present = present_r;
    assign frame_valid = frame_valid_r;
    assign state       = state_s;
    assign left_p      = left_p_r;
    assign right_p     = right_p_r;
    assign center_p    = center_p_r;
endmodule
